// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: source numbering,
// register offsets and the request FSM states.
package irq_pkg;

  localparam int NUM_SOURCES = 16;
  localparam int NUM_GROUPS  = 4;

  localparam int TIMER256_IRQ0 = 0;
  localparam int TIMER256_IRQ1 = 1;
  localparam int TIMER256_IRQ2 = 2;
  localparam int TIMER256_IRQ3 = 3;
  localparam int PRE_TIMER_IRQ0 = 4;
  localparam int PRE_TIMER_IRQ1 = 5;
  localparam int PRE_TIMER_IRQ2 = 6;
  localparam int PRE_TIMER_IRQ3 = 7;
  localparam int KEYPAD_IRQ0 = 8;
  localparam int KEYPAD_IRQ1 = 9;

  localparam logic [23:0] REG_PRIO     = 24'd0;
  localparam logic [23:0] REG_EN_LO    = 24'd1;
  localparam logic [23:0] REG_EN_HI    = 24'd2;
  localparam logic [23:0] REG_FLAGS_LO = 24'd3;
  localparam logic [23:0] REG_FLAGS_HI = 24'd4;

  typedef enum logic [1:0] {
    IRQ_IDLE  = 2'd0,
    IRQ_REQ   = 2'd1,
    IRQ_CLEAR = 2'd2
  } irq_state_t;

  // Index of the lowest set bit of a 4-bit group (0 when none set).
  function automatic logic [1:0] lowestSetBit(input logic [3:0] bits);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bits[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Register bus plus the CPU interrupt handshake; the CPU side is the master.
interface irq_controller_if;

  logic        bus_write;
  logic        bus_read;
  logic [23:0] bus_address_in;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_data_out;
  logic [1:0]  cpu_ilevel;
  logic        irq_ack;
  logic        irq_req;
  logic [7:0]  irq_vector;
  logic [1:0]  irq_level;

  modport master (
    output bus_write, bus_read, bus_address_in, bus_data_in, cpu_ilevel, irq_ack,
    input  bus_data_out, irq_req, irq_vector, irq_level
  );

  modport slave (
    input  bus_write, bus_read, bus_address_in, bus_data_in, cpu_ilevel, irq_ack,
    output bus_data_out, irq_req, irq_vector, irq_level
  );

endinterface

// File: rtl/irq_priority_select.sv
// Combinational arbiter: picks the pending, enabled source in the highest
// priority group above the CPU mask; ties go to the lower group, then lower source.
module irq_priority_select
  import irq_pkg::*;
(
  input  logic [15:0] i_flags,
  input  logic [15:0] i_enables,
  input  logic [7:0]  i_priorities,
  input  logic [1:0]  i_cpu_ilevel,
  output logic        o_valid,
  output logic [3:0]  o_winner,
  output logic [1:0]  o_level
);

  logic [3:0] w_pend [NUM_GROUPS];
  logic [1:0] w_grpPrio [NUM_GROUPS];

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_group
    assign w_pend[g]    = i_flags[4*g +: 4] & i_enables[4*g +: 4];
    assign w_grpPrio[g] = i_priorities[2*g +: 2];
  end

  // Ascending scan replacing only on strictly higher level keeps the lower group on ties.
  always_comb begin
    o_valid  = 1'b0;
    o_winner = 4'd0;
    o_level  = 2'd0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if ((|w_pend[g]) && (w_grpPrio[g] > i_cpu_ilevel) &&
          (!o_valid || (w_grpPrio[g] > o_level))) begin
        o_valid  = 1'b1;
        o_level  = w_grpPrio[g];
        o_winner = {2'(g), lowestSetBit(w_pend[g])};
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Pokemon Mini interrupt controller: latches 16 source edges into flags,
// arbitrates them by group priority and holds one request until the CPU acks.
module irq_controller
  import irq_pkg::*;
#(
  parameter logic [23:0] REG_BASE    = 24'h002020,
  parameter logic [7:0]  VECTOR_BASE = 8'h03
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clk_ce,
  input  logic [15:0]  irq_sources,
  irq_controller_if.slave bus
);

  logic [7:0]  r_prio;
  logic [15:0] r_en;
  logic [15:0] r_flags;
  logic [15:0] r_hist;
  irq_state_t  r_state;
  logic [3:0]  r_idx;
  logic        r_req;
  logic [7:0]  r_vector;
  logic [1:0]  r_level;

  logic        w_selPrio, w_selEnLo, w_selEnHi, w_selFlLo, w_selFlHi;
  logic [7:0]  w_prioNext;
  logic [15:0] w_enNext;
  logic [15:0] w_w1c;
  logic [15:0] w_ackMask;
  logic [15:0] w_edge;
  logic [15:0] w_flagsNext;
  logic        w_latchedOk;
  logic        w_valid;
  logic [3:0]  w_winner;
  logic [1:0]  w_winLevel;
  logic [7:0]  w_rdata;
  logic        w_unused;

  assign w_unused = bus.bus_read;

  assign w_selPrio = (bus.bus_address_in == REG_BASE + REG_PRIO);
  assign w_selEnLo = (bus.bus_address_in == REG_BASE + REG_EN_LO);
  assign w_selEnHi = (bus.bus_address_in == REG_BASE + REG_EN_HI);
  assign w_selFlLo = (bus.bus_address_in == REG_BASE + REG_FLAGS_LO);
  assign w_selFlHi = (bus.bus_address_in == REG_BASE + REG_FLAGS_HI);

  assign w_prioNext  = (bus.bus_write && w_selPrio) ? bus.bus_data_in : r_prio;
  assign w_enNext[7:0]  = (bus.bus_write && w_selEnLo) ? bus.bus_data_in : r_en[7:0];
  assign w_enNext[15:8] = (bus.bus_write && w_selEnHi) ? bus.bus_data_in : r_en[15:8];
  assign w_w1c[7:0]  = (bus.bus_write && w_selFlLo) ? bus.bus_data_in : 8'h00;
  assign w_w1c[15:8] = (bus.bus_write && w_selFlHi) ? bus.bus_data_in : 8'h00;
  assign w_ackMask   = (r_state == IRQ_REQ && bus.irq_ack) ? (16'h0001 << r_idx) : 16'h0000;
  assign w_edge      = irq_sources & ~r_hist;

  // New edges are OR-ed in last so a set always beats a same-cycle clear.
  assign w_flagsNext = (r_flags & ~w_w1c & ~w_ackMask) | w_edge;

  // Withdrawal looks at the post-write state so a clear drops the request immediately.
  assign w_latchedOk = w_flagsNext[r_idx] & w_enNext[r_idx] &
                       (w_prioNext[{r_idx[3:2], 1'b0} +: 2] > bus.cpu_ilevel);

  irq_priority_select u_select (
    .i_flags      (r_flags),
    .i_enables    (r_en),
    .i_priorities (r_prio),
    .i_cpu_ilevel (bus.cpu_ilevel),
    .o_valid      (w_valid),
    .o_winner     (w_winner),
    .o_level      (w_winLevel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio  <= 8'h00;
      r_en    <= 16'h0000;
      r_flags <= 16'h0000;
      r_hist  <= 16'h0000;
    end else if (clk_ce) begin
      r_prio  <= w_prioNext;
      r_en    <= w_enNext;
      r_flags <= w_flagsNext;
      r_hist  <= irq_sources;
    end
  end

  // Request FSM; vector and level are frozen when the request is latched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IRQ_IDLE;
      r_idx    <= 4'd0;
      r_req    <= 1'b0;
      r_vector <= VECTOR_BASE;
      r_level  <= 2'd0;
    end else if (clk_ce) begin
      case (r_state)
        IRQ_IDLE: begin
          if (w_valid) begin
            r_state  <= IRQ_REQ;
            r_idx    <= w_winner;
            r_level  <= w_winLevel;
            r_vector <= VECTOR_BASE + {4'h0, w_winner};
            r_req    <= 1'b1;
          end
        end
        IRQ_REQ: begin
          if (bus.irq_ack) begin
            r_state <= IRQ_CLEAR;
            r_req   <= 1'b0;
          end else if (!w_latchedOk) begin
            r_state <= IRQ_IDLE;
            r_req   <= 1'b0;
          end
        end
        IRQ_CLEAR: begin
          r_state <= IRQ_IDLE;
          r_req   <= 1'b0;
        end
        default: begin
          r_state <= IRQ_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_rdata = 8'h00;
    if (w_selPrio)      w_rdata = r_prio;
    else if (w_selEnLo) w_rdata = r_en[7:0];
    else if (w_selEnHi) w_rdata = r_en[15:8];
    else if (w_selFlLo) w_rdata = r_flags[7:0];
    else if (w_selFlHi) w_rdata = r_flags[15:8];
  end

  assign bus.bus_data_out = w_rdata;
  assign bus.irq_req      = r_req;
  assign bus.irq_vector   = r_vector;
  assign bus.irq_level    = r_level;

endmodule

// File: tb/tb_irq_controller.sv
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model that ranks sources by (group priority, index).
module tb_irq_controller;

  localparam logic [23:0] REG_BASE    = 24'h002020;
  localparam logic [7:0]  VECTOR_BASE = 8'h03;

  logic        clk;
  logic        reset;
  logic        clk_ce;
  logic [15:0] irq_sources;

  irq_controller_if busIf ();

  irq_controller #(
    .REG_BASE    (REG_BASE),
    .VECTOR_BASE (VECTOR_BASE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_ce      (clk_ce),
    .irq_sources (irq_sources),
    .bus         (busIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus for the next cycle
  logic        rst, ce, wr, ack;
  logic [15:0] src;
  logic [23:0] addr;
  logic [7:0]  wdata;
  logic [1:0]  ilevel;

  // Behavioural model (0 = idle, 1 = requesting, 2 = post-ack gap)
  logic [15:0] mFlags, mEn, mPrev;
  logic [7:0]  mPrio, mVector;
  int          mState, mIdx, mLevel;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int groupPrio(input logic [7:0] p, input int idx);
    return int'((p >> (2 * (idx / 4))) & 8'h03);
  endfunction

  // Best source = highest (priority, lowest index) among enabled pending sources above the mask.
  function automatic bit findWinner(input logic [15:0] f, input logic [15:0] e, input logic [7:0] p,
                                    input logic [1:0] il, output int idx, output int lvl);
    int best;
    best = -1;
    idx  = 0;
    lvl  = 0;
    for (int i = 0; i < 16; i++) begin
      if (f[i] && e[i] && groupPrio(p, i) > int'(il)) begin
        if (groupPrio(p, i) * 16 + (15 - i) > best) begin
          best = groupPrio(p, i) * 16 + (15 - i);
          idx  = i;
          lvl  = groupPrio(p, i);
        end
      end
    end
    return best >= 0;
  endfunction

  function automatic logic [7:0] modelRead(input logic [23:0] a);
    logic [23:0] off;
    off = a - REG_BASE;
    case (off)
      24'd0:   return mPrio;
      24'd1:   return mEn[7:0];
      24'd2:   return mEn[15:8];
      24'd3:   return mFlags[7:0];
      24'd4:   return mFlags[15:8];
      default: return 8'h00;
    endcase
  endfunction

  task automatic modelStep();
    logic [15:0] edges, w1c, ackm, nf, ne;
    logic [7:0]  np;
    logic [23:0] off;
    int          wi, wl;
    if (rst) begin
      mFlags = '0; mEn = '0; mPrev = '0; mPrio = '0;
      mState = 0; mIdx = 0; mLevel = 0; mVector = VECTOR_BASE;
    end else if (ce) begin
      edges = src & ~mPrev;
      w1c = '0; ne = mEn; np = mPrio;
      off = addr - REG_BASE;
      if (wr) begin
        case (off)
          24'd0: np = wdata;
          24'd1: ne[7:0] = wdata;
          24'd2: ne[15:8] = wdata;
          24'd3: w1c[7:0] = wdata;
          24'd4: w1c[15:8] = wdata;
          default: ;
        endcase
      end
      ackm = (mState == 1 && ack) ? (16'h0001 << mIdx) : 16'h0000;
      nf = (mFlags & ~w1c & ~ackm) | edges;
      if (mState == 0) begin
        if (findWinner(mFlags, mEn, mPrio, ilevel, wi, wl)) begin
          mState = 1; mIdx = wi; mLevel = wl;
          mVector = VECTOR_BASE + 8'(wi);
        end
      end else if (mState == 1) begin
        if (ack) mState = 2;
        else if (!(nf[mIdx] && ne[mIdx] && groupPrio(np, mIdx) > int'(ilevel))) mState = 0;
      end else begin
        mState = 0;
      end
      mFlags = nf; mEn = ne; mPrio = np; mPrev = src;
    end
  endtask

  // Drives one cycle of stimulus, advances the model and checks the registered outputs.
  task automatic applyStimulus();
    reset = rst; clk_ce = ce; irq_sources = src;
    busIf.bus_write = wr; busIf.bus_read = 1'b0; busIf.bus_address_in = addr;
    busIf.bus_data_in = wdata; busIf.cpu_ilevel = ilevel; busIf.irq_ack = ack;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("req", 32'(busIf.irq_req), 32'(mState == 1));
    checkOutput("vector", 32'(busIf.irq_vector), 32'(mVector));
    checkOutput("level", 32'(busIf.irq_level), 32'(mLevel));
  endtask

  task automatic readCheck(input string tag, input int off);
    addr = REG_BASE + 24'(off);
    busIf.bus_address_in = addr;
    #1;
    checkOutput(tag, 32'(busIf.bus_data_out), 32'(modelRead(addr)));
  endtask

  task automatic readLit(input string tag, input int off, input logic [7:0] exp);
    addr = REG_BASE + 24'(off);
    busIf.bus_address_in = addr;
    #1;
    checkOutput(tag, 32'(busIf.bus_data_out), 32'(exp));
  endtask

  task automatic busWrite(input int off, input logic [7:0] d);
    wr = 1'b1; addr = REG_BASE + 24'(off); wdata = d;
    applyStimulus();
    wr = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1; src = '0; ack = 1'b0; wr = 1'b0; ilevel = 2'd0;
    applyStimulus();
    rst = 1'b0;
  endtask

  task automatic serviceAck();
    for (int k = 0; k < 8 && mState != 1; k++) applyStimulus();
    if (mState != 1) checkOutput("ack_timeout", 32'd0, 32'd1);
    else begin
      ack = 1'b1;
      applyStimulus();
      ack = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; wr = 1'b0; ack = 1'b0; src = '0;
    addr = REG_BASE; wdata = '0; ilevel = 2'd0;
    mFlags = '0; mEn = '0; mPrev = '0; mPrio = '0;
    mState = 0; mIdx = 0; mLevel = 0; mVector = VECTOR_BASE;

    doReset();
    checkOutput("rst_req", 32'(busIf.irq_req), 32'd0);
    checkOutput("rst_vector", 32'(busIf.irq_vector), 32'h03);
    checkOutput("rst_level", 32'(busIf.irq_level), 32'd0);
    readLit("rst_prio", 0, 8'h00);

    // Scenario 1/2: single source, two-cycle latency, ack and clear
    busWrite(0, 8'h03);
    busWrite(1, 8'h01);
    src = 16'h0001; applyStimulus();
    checkOutput("s1_req_early", 32'(busIf.irq_req), 32'd0);
    src = 16'h0000; applyStimulus();
    checkOutput("s1_req", 32'(busIf.irq_req), 32'd1);
    checkOutput("s1_vector", 32'(busIf.irq_vector), 32'h03);
    checkOutput("s1_level", 32'(busIf.irq_level), 32'd3);
    ack = 1'b1; applyStimulus(); ack = 1'b0;
    readLit("s2_flag", 3, 8'h00);
    checkOutput("s2_req_gap", 32'(busIf.irq_req), 32'd0);
    applyStimulus(); applyStimulus();
    checkOutput("s2_req_low", 32'(busIf.irq_req), 32'd0);

    // Scenario 3: group 1 beats group 0, then group 0 is served
    doReset();
    busWrite(0, 8'h09);
    busWrite(1, 8'h11);
    src = 16'h0011; applyStimulus();
    src = 16'h0000; applyStimulus();
    checkOutput("s3_vector_hi", 32'(busIf.irq_vector), 32'h07);
    checkOutput("s3_level_hi", 32'(busIf.irq_level), 32'd2);
    ack = 1'b1; applyStimulus(); ack = 1'b0;
    applyStimulus(); applyStimulus();
    checkOutput("s3_req_lo", 32'(busIf.irq_req), 32'd1);
    checkOutput("s3_vector_lo", 32'(busIf.irq_vector), 32'h03);
    checkOutput("s3_level_lo", 32'(busIf.irq_level), 32'd1);
    serviceAck();

    // Scenario 4: masked by cpu_ilevel until it drops
    doReset();
    ilevel = 2'd2;
    busWrite(0, 8'h02);
    busWrite(1, 8'h01);
    src = 16'h0001; applyStimulus();
    src = 16'h0000; applyStimulus(); applyStimulus(); applyStimulus();
    checkOutput("s4_masked", 32'(busIf.irq_req), 32'd0);
    ilevel = 2'd1; applyStimulus();
    checkOutput("s4_unmasked", 32'(busIf.irq_req), 32'd1);
    serviceAck();
    ilevel = 2'd0;

    // Scenario 5: software clear withdraws; edge beats same-cycle W1C
    doReset();
    busWrite(0, 8'h03);
    busWrite(1, 8'h01);
    src = 16'h0001; applyStimulus();
    src = 16'h0000; applyStimulus();
    checkOutput("s5_req", 32'(busIf.irq_req), 32'd1);
    busWrite(3, 8'h01);
    checkOutput("s5_withdrawn", 32'(busIf.irq_req), 32'd0);
    src = 16'h0001; busWrite(3, 8'h01);
    readLit("s5_set_wins", 3, 8'h01);
    src = 16'h0000;
    serviceAck();

    // Scenario 6: held source sets once; disabled source flags but never requests
    doReset();
    src = 16'h0002; applyStimulus();
    busWrite(3, 8'h02);
    for (int k = 0; k < 8; k++) applyStimulus();
    readLit("s6_held_once", 3, 8'h00);
    busWrite(0, 8'h03);
    src = 16'h0004; applyStimulus();
    src = 16'h0000; applyStimulus(); applyStimulus();
    readLit("s6_disabled_flag", 3, 8'h04);
    checkOutput("s6_disabled_req", 32'(busIf.irq_req), 32'd0);
    readLit("s6_unmapped", 5, 8'h00);

    // Randomized traffic
    doReset();
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 499) == 0);
      ce  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) == 0) src = 16'($urandom) & 16'($urandom) & 16'($urandom);
      wr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) addr = 24'($urandom);
      else addr = REG_BASE + 24'($urandom_range(0, 6));
      wdata = 8'($urandom);
      if ($urandom_range(0, 15) == 0) ilevel = 2'($urandom_range(0, 3));
      ack = (mState == 1) && ($urandom_range(0, 1) == 1);
      applyStimulus();
      wr = 1'b0; ack = 1'b0;
      readCheck("rand_read", $urandom_range(0, 5));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
